// File: rtl/pulse_conditioner_if.sv
// Control and status bundle for the pulse conditioner.
// master drives the raw pin and controls; slave returns the strobe, level and statistics.
interface pulse_conditioner_if #(
  parameter int unsigned CNT_W = 16
);
  logic             en;
  logic             signal;
  logic             clear_counts;
  logic             detection;
  logic             level;
  logic             busy;
  logic [CNT_W-1:0] pulse_count;
  logic [CNT_W-1:0] glitch_count;

  modport master (
    output en,
    output signal,
    output clear_counts,
    input  detection,
    input  level,
    input  busy,
    input  pulse_count,
    input  glitch_count
  );

  modport slave (
    input  en,
    input  signal,
    input  clear_counts,
    output detection,
    output level,
    output busy,
    output pulse_count,
    output glitch_count
  );
endinterface

// File: rtl/pulse_conditioner.sv
// Synchronises an asynchronous pulse pin, filters glitches and applies a post-pulse holdoff.
// Emits one detection strobe per accepted rising edge and keeps saturating statistics.
module pulse_conditioner #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned FILTER_CYCLES  = 16,
  parameter int unsigned HOLDOFF_CYCLES = 100,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                clk,
  input  logic                rst,
  pulse_conditioner_if.slave  bus
);

  localparam int unsigned CNT_LIMIT = (FILTER_CYCLES > HOLDOFF_CYCLES) ? FILTER_CYCLES
                                                                       : HOLDOFF_CYCLES;
  localparam int unsigned CW        = $clog2(CNT_LIMIT + 1);
  localparam bit          HAS_HOLD  = (HOLDOFF_CYCLES != 0);
  localparam logic [CW-1:0] FILT_LAST = CW'(FILTER_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HAS_HOLD ? (HOLDOFF_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CNT_W-1:0] STAT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STAT_ONE = CNT_W'(1);

  typedef enum logic [2:0] {
    S_LOW,
    S_QUAL_HIGH,
    S_HIGH,
    S_QUAL_LOW,
    S_HOLDOFF
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   det_q, det_d;
  logic                   level_q, level_d;
  logic                   busy_q, busy_d;
  logic [CNT_W-1:0]       pulse_count_q, pulse_count_d;
  logic [CNT_W-1:0]       glitch_count_q, glitch_count_d;
  logic                   sync_in;
  logic                   pulse_inc;
  logic                   glitch_inc;

  // Metastability chain; the FSM only ever looks at the last stage.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.signal};
  end

  assign sync_in = sync_q[SYNC_STAGES-1];

  // Qualification / holdoff state machine.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    det_d      = 1'b0;
    pulse_inc  = 1'b0;
    glitch_inc = 1'b0;

    if (!bus.en) begin
      state_d = S_LOW;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_LOW: begin
          if (sync_in) begin
            state_d = S_QUAL_HIGH;
            cnt_d   = CNT_ONE;
          end
        end

        S_QUAL_HIGH: begin
          if (!sync_in) begin
            state_d    = S_LOW;
            cnt_d      = '0;
            glitch_inc = 1'b1;
          end else if (cnt_q == FILT_LAST) begin
            state_d   = S_HIGH;
            cnt_d     = '0;
            det_d     = 1'b1;
            pulse_inc = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_HIGH: begin
          if (!sync_in) begin
            state_d = S_QUAL_LOW;
            cnt_d   = CNT_ONE;
          end
        end

        S_QUAL_LOW: begin
          if (sync_in) begin
            state_d    = S_HIGH;
            cnt_d      = '0;
            glitch_inc = 1'b1;
          end else if (cnt_q == FILT_LAST) begin
            state_d = HAS_HOLD ? S_HOLDOFF : S_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        S_HOLDOFF: begin
          // Input is deliberately ignored here: no qualification, no glitch counting.
          if (cnt_q == HOLD_LAST) begin
            state_d = S_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end

        default: begin
          state_d = S_LOW;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Status outputs follow the next state so level rises together with detection.
  always_comb begin
    level_d = (state_d == S_HIGH) || (state_d == S_QUAL_LOW);
    busy_d  = (state_d != S_LOW);
  end

  // Saturating statistics; a clear wins over a same-cycle increment.
  always_comb begin
    pulse_count_d  = pulse_count_q;
    glitch_count_d = glitch_count_q;
    if (bus.clear_counts) begin
      pulse_count_d  = '0;
      glitch_count_d = '0;
    end else begin
      if (pulse_inc && (pulse_count_q != STAT_MAX)) begin
        pulse_count_d = pulse_count_q + STAT_ONE;
      end
      if (glitch_inc && (glitch_count_q != STAT_MAX)) begin
        glitch_count_d = glitch_count_q + STAT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_LOW;
      sync_q         <= '0;
      cnt_q          <= '0;
      det_q          <= 1'b0;
      level_q        <= 1'b0;
      busy_q         <= 1'b0;
      pulse_count_q  <= '0;
      glitch_count_q <= '0;
    end else begin
      state_q        <= state_d;
      sync_q         <= sync_d;
      cnt_q          <= cnt_d;
      det_q          <= det_d;
      level_q        <= level_d;
      busy_q         <= busy_d;
      pulse_count_q  <= pulse_count_d;
      glitch_count_q <= glitch_count_d;
    end
  end

  assign bus.detection    = det_q;
  assign bus.level        = level_q;
  assign bus.busy         = busy_q;
  assign bus.pulse_count  = pulse_count_q;
  assign bus.glitch_count = glitch_count_q;

endmodule

// File: tb/tb_pulse_conditioner.sv
// Directed bench for pulse_conditioner: two instances share stimulus, the second
// uses 4-bit statistics so saturation can be reached quickly.
module tb_pulse_conditioner;

  logic clk          = 1'b0;
  logic rst          = 1'b1;
  logic en           = 1'b0;
  logic signal       = 1'b0;
  logic clear_counts = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int det_cnt      = 0;
  int det_cyc      = 0;
  int consec_err   = 0;
  int lvl_rise     = 0;
  int lvl_fall     = 0;
  int lvl_rise_cyc = 0;
  bit prev_det     = 1'b0;
  bit prev_level   = 1'b0;

  always #5 clk = ~clk;

  pulse_conditioner_if #(.CNT_W(16)) bus_a ();
  pulse_conditioner_if #(.CNT_W(4))  bus_b ();

  assign bus_a.en           = en;
  assign bus_a.signal       = signal;
  assign bus_a.clear_counts = clear_counts;
  assign bus_b.en           = en;
  assign bus_b.signal       = signal;
  assign bus_b.clear_counts = clear_counts;

  pulse_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(16), .HOLDOFF_CYCLES(100), .CNT_W(16)
  ) dut_a (
    .clk(clk), .rst(rst), .bus(bus_a)
  );

  pulse_conditioner #(
    .SYNC_STAGES(2), .FILTER_CYCLES(16), .HOLDOFF_CYCLES(100), .CNT_W(4)
  ) dut_b (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe and level activity of instance A, observed mid-cycle.
  always @(negedge clk) begin
    if (bus_a.detection === 1'b1) begin
      det_cnt = det_cnt + 1;
      det_cyc = cyc;
      if (prev_det) consec_err = consec_err + 1;
    end
    prev_det = (bus_a.detection === 1'b1);
    if ((bus_a.level === 1'b1) && !prev_level) begin
      lvl_rise     = lvl_rise + 1;
      lvl_rise_cyc = cyc;
    end
    if ((bus_a.level !== 1'b1) && prev_level) lvl_fall = lvl_fall + 1;
    prev_level = (bus_a.level === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    clear_counts = 1'b1;
    tick(1);
    clear_counts = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    tick(3);
    n_checks++; if (bus_a.detection !== 1'b0) begin n_fail++; $display("FAIL reset_detection: got %b expected 0", bus_a.detection); end
    n_checks++; if (bus_a.level !== 1'b0) begin n_fail++; $display("FAIL reset_level: got %b expected 0", bus_a.level); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus_a.busy); end
    n_checks++; if (bus_a.pulse_count !== 16'd0) begin n_fail++; $display("FAIL reset_pulse_count: got %0d expected 0", bus_a.pulse_count); end
    n_checks++; if (bus_a.glitch_count !== 16'd0) begin n_fail++; $display("FAIL reset_glitch_count: got %0d expected 0", bus_a.glitch_count); end
    n_checks++; if (bus_b.pulse_count !== 4'd0) begin n_fail++; $display("FAIL reset_pulse_count_b: got %0d expected 0", bus_b.pulse_count); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_clean_pulse();
    int base, t0;
    base = det_cnt;
    t0   = cyc;
    signal = 1'b1;
    tick(50);
    signal = 1'b0;
    tick(140);
    n_checks++; if (det_cnt - base !== 1) begin n_fail++; $display("FAIL clean_strobes: got %0d expected 1", det_cnt - base); end
    n_checks++; if (det_cyc - t0 !== 18) begin n_fail++; $display("FAIL clean_latency: got %0d expected 18", det_cyc - t0); end
    n_checks++; if (lvl_rise_cyc !== det_cyc) begin n_fail++; $display("FAIL clean_level_rise: got cycle %0d expected %0d", lvl_rise_cyc, det_cyc); end
    n_checks++; if (bus_a.pulse_count !== 16'd1) begin n_fail++; $display("FAIL clean_pulse_count: got %0d expected 1", bus_a.pulse_count); end
    n_checks++; if (bus_a.glitch_count !== 16'd0) begin n_fail++; $display("FAIL clean_glitch_count: got %0d expected 0", bus_a.glitch_count); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL clean_busy_after: got %b expected 0", bus_a.busy); end
  endtask

  task automatic test_glitch();
    int base, rise0, t0;
    pulse_clear();
    base  = det_cnt;
    rise0 = lvl_rise;
    signal = 1'b1;
    tick(15);
    signal = 1'b0;
    tick(30);
    n_checks++; if (det_cnt - base !== 0) begin n_fail++; $display("FAIL glitch15_strobes: got %0d expected 0", det_cnt - base); end
    n_checks++; if (bus_a.glitch_count !== 16'd1) begin n_fail++; $display("FAIL glitch15_glitch_count: got %0d expected 1", bus_a.glitch_count); end
    n_checks++; if (lvl_rise - rise0 !== 0) begin n_fail++; $display("FAIL glitch15_level_rises: got %0d expected 0", lvl_rise - rise0); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL glitch15_busy: got %b expected 0", bus_a.busy); end
    t0 = cyc;
    signal = 1'b1;
    tick(16);
    signal = 1'b0;
    tick(140);
    n_checks++; if (det_cnt - base !== 1) begin n_fail++; $display("FAIL glitch16_strobes: got %0d expected 1", det_cnt - base); end
    n_checks++; if (det_cyc - t0 !== 18) begin n_fail++; $display("FAIL glitch16_latency: got %0d expected 18", det_cyc - t0); end
    n_checks++; if (bus_a.pulse_count !== 16'd1) begin n_fail++; $display("FAIL glitch16_pulse_count: got %0d expected 1", bus_a.pulse_count); end
    n_checks++; if (bus_a.glitch_count !== 16'd1) begin n_fail++; $display("FAIL glitch16_glitch_count: got %0d expected 1", bus_a.glitch_count); end
  endtask

  task automatic test_bounce();
    int base, fall0;
    pulse_clear();
    base  = det_cnt;
    fall0 = lvl_fall;
    signal = 1'b1;
    tick(30);
    repeat (3) begin
      signal = 1'b0;
      tick(5);
      signal = 1'b1;
      tick(5);
    end
    signal = 1'b0;
    tick(40);
    tick(110);
    n_checks++; if (bus_a.glitch_count !== 16'd3) begin n_fail++; $display("FAIL bounce_glitch_count: got %0d expected 3", bus_a.glitch_count); end
    n_checks++; if (bus_a.pulse_count !== 16'd1) begin n_fail++; $display("FAIL bounce_pulse_count: got %0d expected 1", bus_a.pulse_count); end
    n_checks++; if (det_cnt - base !== 1) begin n_fail++; $display("FAIL bounce_strobes: got %0d expected 1", det_cnt - base); end
    n_checks++; if (lvl_fall - fall0 !== 1) begin n_fail++; $display("FAIL bounce_level_falls: got %0d expected 1", lvl_fall - fall0); end
    n_checks++; if (bus_a.level !== 1'b0) begin n_fail++; $display("FAIL bounce_level_end: got %b expected 0", bus_a.level); end
  endtask

  task automatic test_holdoff();
    int base, m;
    pulse_clear();
    base = det_cnt;
    signal = 1'b1;
    tick(30);
    signal = 1'b0;
    m = cyc;
    tick(68);
    signal = 1'b1;
    tick(200);
    signal = 1'b0;
    tick(140);
    n_checks++; if (det_cnt - base !== 2) begin n_fail++; $display("FAIL holdoff_strobes: got %0d expected 2", det_cnt - base); end
    n_checks++; if (det_cyc - m !== 134) begin n_fail++; $display("FAIL holdoff_latency: got %0d expected 134", det_cyc - m); end
    n_checks++; if (bus_a.glitch_count !== 16'd0) begin n_fail++; $display("FAIL holdoff_glitch_count: got %0d expected 0", bus_a.glitch_count); end
    n_checks++; if (bus_a.pulse_count !== 16'd2) begin n_fail++; $display("FAIL holdoff_pulse_count: got %0d expected 2", bus_a.pulse_count); end
  endtask

  task automatic test_saturation();
    int base, t0;
    pulse_clear();
    base = det_cnt;
    repeat (20) begin
      signal = 1'b1;
      tick(20);
      signal = 1'b0;
      tick(130);
    end
    n_checks++; if (det_cnt - base !== 20) begin n_fail++; $display("FAIL sat_strobes: got %0d expected 20", det_cnt - base); end
    n_checks++; if (bus_a.pulse_count !== 16'd20) begin n_fail++; $display("FAIL sat_pulse_count_a: got %0d expected 20", bus_a.pulse_count); end
    n_checks++; if (bus_b.pulse_count !== 4'd15) begin n_fail++; $display("FAIL sat_pulse_count_b: got %0d expected 15", bus_b.pulse_count); end
    n_checks++; if (bus_b.glitch_count !== 4'd0) begin n_fail++; $display("FAIL sat_glitch_count_b: got %0d expected 0", bus_b.glitch_count); end
    t0 = cyc;
    signal = 1'b1;
    tick(17);
    clear_counts = 1'b1;
    tick(1);
    clear_counts = 1'b0;
    n_checks++; if (bus_a.detection !== 1'b1) begin n_fail++; $display("FAIL clr_same_cycle_strobe: got %b expected 1 at offset %0d", bus_a.detection, cyc - t0); end
    n_checks++; if (bus_a.pulse_count !== 16'd0) begin n_fail++; $display("FAIL clr_same_cycle_count_a: got %0d expected 0", bus_a.pulse_count); end
    n_checks++; if (bus_b.pulse_count !== 4'd0) begin n_fail++; $display("FAIL clr_same_cycle_count_b: got %0d expected 0", bus_b.pulse_count); end
    signal = 1'b0;
    tick(140);
  endtask

  task automatic test_reset_mid();
    int base, r;
    base = det_cnt;
    signal = 1'b1;
    tick(8);
    rst = 1'b1;
    tick(1);
    n_checks++; if (bus_a.detection !== 1'b0) begin n_fail++; $display("FAIL midrst_detection: got %b expected 0", bus_a.detection); end
    n_checks++; if (bus_a.level !== 1'b0) begin n_fail++; $display("FAIL midrst_level: got %b expected 0", bus_a.level); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus_a.busy); end
    n_checks++; if (bus_a.pulse_count !== 16'd0) begin n_fail++; $display("FAIL midrst_pulse_count: got %0d expected 0", bus_a.pulse_count); end
    n_checks++; if (bus_a.glitch_count !== 16'd0) begin n_fail++; $display("FAIL midrst_glitch_count: got %0d expected 0", bus_a.glitch_count); end
    rst = 1'b0;
    r = cyc;
    tick(40);
    n_checks++; if (det_cnt - base !== 1) begin n_fail++; $display("FAIL midrst_strobes: got %0d expected 1", det_cnt - base); end
    n_checks++; if (det_cyc - r !== 18) begin n_fail++; $display("FAIL midrst_requal_latency: got %0d expected 18", det_cyc - r); end
    signal = 1'b0;
    tick(140);
  endtask

  task automatic test_enable();
    int base, e;
    logic [15:0] pc0, gc0;
    base = det_cnt;
    pc0  = bus_a.pulse_count;
    gc0  = bus_a.glitch_count;
    en = 1'b0;
    signal = 1'b1;
    tick(100);
    n_checks++; if (det_cnt - base !== 0) begin n_fail++; $display("FAIL dis_strobes: got %0d expected 0", det_cnt - base); end
    n_checks++; if (bus_a.busy !== 1'b0) begin n_fail++; $display("FAIL dis_busy: got %b expected 0", bus_a.busy); end
    n_checks++; if (bus_a.level !== 1'b0) begin n_fail++; $display("FAIL dis_level: got %b expected 0", bus_a.level); end
    n_checks++; if (bus_a.pulse_count !== pc0) begin n_fail++; $display("FAIL dis_pulse_count: got %0d expected %0d", bus_a.pulse_count, pc0); end
    n_checks++; if (bus_a.glitch_count !== gc0) begin n_fail++; $display("FAIL dis_glitch_count: got %0d expected %0d", bus_a.glitch_count, gc0); end
    en = 1'b1;
    e = cyc;
    tick(30);
    n_checks++; if (det_cnt - base !== 1) begin n_fail++; $display("FAIL reen_strobes: got %0d expected 1", det_cnt - base); end
    n_checks++; if (det_cyc - e !== 16) begin n_fail++; $display("FAIL reen_latency: got %0d expected 16", det_cyc - e); end
    n_checks++; if (bus_a.pulse_count !== pc0 + 16'd1) begin n_fail++; $display("FAIL reen_pulse_count: got %0d expected %0d", bus_a.pulse_count, pc0 + 16'd1); end
    signal = 1'b0;
    tick(140);
  endtask

  initial begin
    test_reset();
    test_clean_pulse();
    test_glitch();
    test_bounce();
    test_holdoff();
    test_saturation();
    test_reset_mid();
    test_enable();
    n_checks++; if (consec_err !== 0) begin n_fail++; $display("FAIL strobe_back_to_back: got %0d adjacent strobes expected 0", consec_err); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
